// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: arbitrates fetch and load/store onto an 8-bit single-port bus.
// Optional: define MEM_CTRL_IO_STALL_EN to hold IO-space store bytes while io_buffer_full is high.
module mem_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'h00030000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  clear,
  input  logic                  if_sig,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_sig,
  input  logic                  load_or_store,
  input  logic [2:0]            len,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           store_val,
  output logic                  ls_done,
  output logic [31:0]           ls_data
);

  typedef enum logic [2:0] {StIdle, StIfetch, StLoad, StStore, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           sval_q, sval_d;
  logic [31:0]           buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  if_done_q, if_done_d;
  logic                  ls_done_q, ls_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           ls_data_q, ls_data_d;

  logic [2:0]            req_n;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [31:0]           sval_sh;
  logic                  stall;

  assign req_n   = len[2] ? 3'd4 : (len[1] ? 3'd2 : 3'd1);
  // Address of the store byte about to be driven: the request itself when accepting.
  assign st_addr = (state_q == StIdle) ? ls_addr : base_q + ADDR_WIDTH'(cnt_q);
  assign sval_sh = sval_q >> {cnt_q, 3'b000};

`ifdef MEM_CTRL_IO_STALL_EN
  assign stall = io_buffer_full && (st_addr >= IO_BASE);
  logic unused_len;
  assign unused_len = len[0];
`else
  assign stall = 1'b0;
  logic unused_io;
  assign unused_io = ^{io_buffer_full, len[0], IO_BASE};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    base_d     = base_q;
    sval_d     = sval_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    if_done_d  = if_done_q;
    ls_done_d  = ls_done_q;
    if_data_d  = if_data_q;
    ls_data_d  = ls_data_q;
    if (rdy) begin
      unique case (state_q)
        StIdle: begin
          if (!clear && ls_sig) begin
            base_d  = ls_addr;
            n_d     = req_n;
            sval_d  = store_val;
            buf_d   = '0;
            if (load_or_store) begin
              state_d = StStore;
              cnt_d   = 3'd0;
              if (!stall) begin
                mem_a_d    = ls_addr;
                mem_dout_d = store_val[7:0];
                mem_wr_d   = 1'b1;
                cnt_d      = 3'd1;
              end
            end else begin
              state_d = StLoad;
              mem_a_d = ls_addr;
              cnt_d   = 3'd1;
            end
          end else if (!clear && if_sig) begin
            state_d = StIfetch;
            base_d  = if_addr;
            n_d     = 3'd4;
            buf_d   = '0;
            mem_a_d = if_addr;
            cnt_d   = 3'd1;
          end
        end
        StIfetch, StLoad: begin
          if (clear) begin
            state_d = StIdle;
          end else begin
            if (cnt_q < n_q) mem_a_d = base_q + ADDR_WIDTH'(cnt_q);
            // Read data trails its address by two edges.
            if (cnt_q >= 3'd2) buf_d = buf_q | (32'(mem_din) << {cnt_q - 3'd2, 3'b000});
            if (cnt_q == n_q + 3'd1) begin
              state_d = StDone;
              if (state_q == StIfetch) begin
                if_done_d = 1'b1;
                if_data_d = buf_d;
              end else begin
                ls_done_d = 1'b1;
                ls_data_d = buf_d;
              end
            end
            cnt_d = cnt_q + 3'd1;
          end
        end
        StStore: begin
          if (cnt_q < n_q) begin
            if (!stall) begin
              mem_a_d    = st_addr;
              mem_dout_d = sval_sh[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = cnt_q + 3'd1;
            end
          end else begin
            ls_done_d = 1'b1;
            state_d   = StDone;
          end
        end
        StDone: begin
          if_done_d = 1'b0;
          ls_done_d = 1'b0;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      n_q        <= '0;
      base_q     <= '0;
      sval_q     <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      base_q     <= base_d;
      sval_q     <= sval_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_data_q  <= ls_data_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_data  = if_data_q;
  assign ls_data  = ls_data_q;

endmodule
